// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the MAC accumulator: FSM state encoding and term counter width.
// The bench imports this package for its state checks.
package mac_accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2,
        S_RSVD  = 2'd3
    } state_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mac_accumulator_term_counter.sv
// Counts accepted products within one accumulation and flags the final term.
// Keeps counter arithmetic out of the accumulator FSM.
module mac_accumulator_term_counter
    import mac_accumulator_pkg::*;
#(
    parameter int COUNT_N = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // High while the next accept is the COUNT_N-th term of the run.
    assign o_last = (r_count == CNT_W'(COUNT_N - 1));

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates COUNT_N unsigned products into one registered sum and hands it
// downstream over a valid/ready handshake; sticky OVERFLOW flags a wrap.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int COUNT_N   = 4,
    parameter int ACC_WIDTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_in_valid,
    input  logic [2*WIDTH-1:0]   i_product,
    output logic                 o_in_ready,
    output logic [ACC_WIDTH-1:0] o_acc_out,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic [1:0]           o_state
);

    // Handshakes: a product transfers on a rising edge where i_in_valid and
    // o_in_ready are both high; a result transfers where o_out_valid and
    // i_out_ready are both high. Neither valid may depend on its ready.

    state_t               r_state;
    state_t               w_next_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_acc_out;
    logic                 r_overflow;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_busy;
    logic                 w_start_run;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_final;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_start_run = (r_state == S_IDLE) && i_start;
    assign w_accept    = (r_state == S_ACCUM) && i_in_valid;
    assign w_final     = w_accept && w_last;
    // Extra top bit captures the carry out of the accumulator.
    assign w_sum       = {1'b0, r_acc} + (ACC_WIDTH + 1)'(i_product);

    mac_accumulator_term_counter #(
        .COUNT_N (COUNT_N)
    ) u_term_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_start_run),
        .i_inc   (w_accept),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start)     w_next_state = S_ACCUM;
            S_ACCUM: if (w_final)     w_next_state = S_DONE;
            S_DONE:  if (i_out_ready) w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_ACCUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_acc_out  <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_run) begin
            r_acc      <= '0;
            r_acc_out  <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            if (w_sum[ACC_WIDTH]) begin
                r_overflow <= 1'b1;
            end
            if (w_last) begin
                r_acc_out <= w_sum[ACC_WIDTH-1:0];
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_busy      = w_busy;
    assign o_acc_out   = r_acc_out;
    assign o_overflow  = r_overflow;
    assign o_state     = r_state;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default, 9-bit accumulator and COUNT_N=1
// instances share one set of drivers, gated by the selected instance.
module tb_mac_accumulator;
    import mac_accumulator_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] product;
    int         cur;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];

    logic       in_ready0, out_valid0, busy0, ovf0;
    logic       in_ready1, out_valid1, busy1, ovf1;
    logic       in_ready2, out_valid2, busy2, ovf2;
    logic [1:0] state0, state1, state2;
    logic [9:0] acc0, acc2;
    logic [8:0] acc1;

    mac_accumulator #(.WIDTH(4), .COUNT_N(4), .ACC_WIDTH(10)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start && cur == 0),
        .i_in_valid(in_valid && cur == 0), .i_product(product),
        .o_in_ready(in_ready0), .o_acc_out(acc0), .o_out_valid(out_valid0),
        .i_out_ready(out_ready && cur == 0), .o_busy(busy0),
        .o_overflow(ovf0), .o_state(state0)
    );

    mac_accumulator #(.WIDTH(4), .COUNT_N(4), .ACC_WIDTH(9)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start && cur == 1),
        .i_in_valid(in_valid && cur == 1), .i_product(product),
        .o_in_ready(in_ready1), .o_acc_out(acc1), .o_out_valid(out_valid1),
        .i_out_ready(out_ready && cur == 1), .o_busy(busy1),
        .o_overflow(ovf1), .o_state(state1)
    );

    mac_accumulator #(.WIDTH(4), .COUNT_N(1), .ACC_WIDTH(10)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start && cur == 2),
        .i_in_valid(in_valid && cur == 2), .i_product(product),
        .o_in_ready(in_ready2), .o_acc_out(acc2), .o_out_valid(out_valid2),
        .i_out_ready(out_ready && cur == 2), .o_busy(busy2),
        .o_overflow(ovf2), .o_state(state2)
    );

    logic       m_in_ready, m_out_valid, m_busy, m_ovf;
    logic [1:0] m_state;
    logic [9:0] m_acc;

    always_comb begin
        m_in_ready  = in_ready0;
        m_out_valid = out_valid0;
        m_busy      = busy0;
        m_ovf       = ovf0;
        m_state     = state0;
        m_acc       = acc0;
        if (cur == 1) begin
            m_in_ready  = in_ready1;
            m_out_valid = out_valid1;
            m_busy      = busy1;
            m_ovf       = ovf1;
            m_state     = state1;
            m_acc       = {1'b0, acc1};
        end else if (cur == 2) begin
            m_in_ready  = in_ready2;
            m_out_valid = out_valid2;
            m_busy      = busy2;
            m_ovf       = ovf2;
            m_state     = state2;
            m_acc       = acc2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] p, input int gap);
        in_valid = 1'b1;
        product  = p;
        tick();
        in_valid = 1'b0;
        product  = 8'd0;
        repeat (gap) tick();
    endtask

    task automatic collect(input string tag, input int hold, input logic [31:0] exp_ovf);
        logic [9:0] exp;
        exp = exp_q.pop_front();
        check({tag, "_valid"}, 32'(m_out_valid), 1);
        check({tag, "_sum"}, 32'(m_acc), 32'(exp));
        check({tag, "_ovf"}, 32'(m_ovf), exp_ovf);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(m_out_valid), 1);
            check({tag, "_hold_sum"}, 32'(m_acc), 32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(m_out_valid), 0);
        check({tag, "_idle"}, 32'(m_state), 32'(S_IDLE));
        check({tag, "_keep_sum"}, 32'(m_acc), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp;
        cur       = 0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        product   = 8'd0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(m_state), 32'(S_IDLE));
        check("rst_acc", 32'(m_acc), 0);
        check("rst_valid", 32'(m_out_valid), 0);
        check("rst_ready", 32'(m_in_ready), 0);
        check("rst_busy", 32'(m_busy), 0);
        check("rst_ovf", 32'(m_ovf), 0);
        rst = 1'b0;
        tick();

        // 15*15 four times back to back
        do_start();
        check("basic_state", 32'(m_state), 32'(S_ACCUM));
        check("basic_ready", 32'(m_in_ready), 1);
        check("basic_busy", 32'(m_busy), 1);
        exp_q.push_back(10'd900);
        repeat (4) send(8'd225, 0);
        check("basic_done", 32'(m_state), 32'(S_DONE));
        collect("basic", 0, 0);
        check("basic_busy_off", 32'(m_busy), 0);

        // gaps between products and downstream backpressure
        do_start();
        exp_q.push_back(10'd53);
        send(8'd6, 2);
        check("gap_acc_unpublished", 32'(m_acc), 0);
        check("gap_ready", 32'(m_in_ready), 1);
        send(8'd0, 2);
        send(8'd12, 2);
        check("gap_not_done", 32'(m_out_valid), 0);
        send(8'd35, 0);
        collect("gap", 5, 0);

        // 9-bit accumulator wraps: 900 mod 512
        cur = 1;
        do_start();
        exp_q.push_back(10'd388);
        repeat (4) send(8'd225, 0);
        collect("wrap", 0, 1);
        do_start();
        check("wrap_clear_ovf", 32'(m_ovf), 0);
        check("wrap_clear_acc", 32'(m_acc), 0);

        // asynchronous reset in the middle of a run
        cur = 0;
        do_start();
        send(8'd100, 0);
        send(8'd100, 0);
        #2 rst = 1'b1;
        #1;
        check("amid_rst_state", 32'(m_state), 32'(S_IDLE));
        check("amid_rst_ready", 32'(m_in_ready), 0);
        check("amid_rst_busy", 32'(m_busy), 0);
        check("amid_rst_acc", 32'(m_acc), 0);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_state", 32'(m_state), 32'(S_IDLE));
        check("post_rst_valid", 32'(m_out_valid), 0);
        do_start();
        exp_q.push_back(10'd10);
        send(8'd1, 0);
        send(8'd2, 0);
        send(8'd3, 0);
        send(8'd4, 0);
        collect("rst_run", 0, 0);

        // START in ACCUM and in the DONE handshake cycle is ignored
        do_start();
        exp_q.push_back(10'd20);
        send(8'd5, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_accum_state", 32'(m_state), 32'(S_ACCUM));
        repeat (3) send(8'd5, 0);
        exp = exp_q.pop_front();
        check("ign_valid", 32'(m_out_valid), 1);
        check("ign_sum", 32'(m_acc), 32'(exp));
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("ign_hs_state", 32'(m_state), 32'(S_IDLE));
        check("ign_hs_valid", 32'(m_out_valid), 0);
        tick();
        check("ign_stay_idle", 32'(m_state), 32'(S_IDLE));
        check("ign_stay_busy", 32'(m_busy), 0);
        check("ign_keep_sum", 32'(m_acc), 32'(exp));

        // COUNT_N=1: first accept completes the run
        cur = 2;
        do_start();
        exp_q.push_back(10'd42);
        send(8'd42, 0);
        collect("n1", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
